// File: rtl/conv_13_acc_pkg.sv
// conv_13_acc_pkg
// Shared widths, output limits and data typedefs for the conv_13 accumulate /
// round / saturate stage. The DEF_* values are the default widths; modules
// take them as parameter defaults so the stage can be re-sized per instance.
// Optional feature macro used by this block: CONV_13_RELU_EN.
package conv_13_acc_pkg;

  localparam int DEF_PROD_W = 24;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_KLEN   = 9;
  localparam int DEF_SHIFT  = 8;

  typedef logic signed [DEF_PROD_W-1:0] prod_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;
  typedef logic signed [DEF_OUT_W-1:0]  out_t;

  // Signed output limits at the default output width.
  localparam out_t OUT_MAX = out_t'({1'b0, {(DEF_OUT_W-1){1'b1}}});
  localparam out_t OUT_MIN = out_t'({1'b1, {(DEF_OUT_W-1){1'b0}}});

endpackage : conv_13_acc_pkg

// File: rtl/conv_13_acc_round_sat_round_sat.sv
// conv_13_round_sat
// Purely combinational round-half-up arithmetic right shift followed by
// signed saturation of the final window sum.
// Ports:
//   sum_i  in  ACC_W  signed final sum (bias + all taps)
//   res_o  out OUT_W  signed rounded / clipped result
//   sat_o  out 1      result was clipped
// Macro CONV_13_RELU_EN: when defined, negative results become 0 and only
// positive clipping raises sat_o.
module conv_13_round_sat
  import conv_13_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [ACC_W-1:0] sum_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    sat_o
);

  // Work one bit wider than the accumulator so adding the rounding constant
  // to a near-maximum sum cannot wrap.
  localparam logic signed [ACC_W:0] HALF_C =
    {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAX_C =
    {{(ACC_W+1-OUT_W){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_C =
    {{(ACC_W+1-OUT_W){1'b1}}, 1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX_C = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN_C = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0]   ext_s;
  logic signed [ACC_W:0]   rnd_s;
  logic signed [ACC_W:0]   shr_s;
  logic signed [OUT_W-1:0] clip_s;
  logic                    clip_sat_s;

  assign ext_s = {sum_i[ACC_W-1], sum_i};
  assign rnd_s = ext_s + HALF_C;
  assign shr_s = rnd_s >>> SHIFT;

  // Signed saturation of the shifted value to the output range.
  always_comb begin
    clip_s     = shr_s[OUT_W-1:0];
    clip_sat_s = 1'b0;
    if (shr_s > MAX_C) begin
      clip_s     = OUT_MAX_C;
      clip_sat_s = 1'b1;
    end else if (shr_s < MIN_C) begin
      clip_s     = OUT_MIN_C;
      clip_sat_s = 1'b1;
    end else begin
      clip_s     = shr_s[OUT_W-1:0];
      clip_sat_s = 1'b0;
    end
  end

`ifdef CONV_13_RELU_EN
  // Rectify: a negative result (clipped or not) becomes 0 and is not flagged.
  always_comb begin
    res_o = clip_s;
    sat_o = clip_sat_s;
    if (clip_s[OUT_W-1]) begin
      res_o = {OUT_W{1'b0}};
      sat_o = 1'b0;
    end else begin
      res_o = clip_s;
      sat_o = clip_sat_s;
    end
  end
`else
  // Signed output passes straight through.
  always_comb begin
    res_o = clip_s;
    sat_o = clip_sat_s;
  end
`endif

endmodule : conv_13_round_sat

// File: rtl/conv_13_acc_round_sat.sv
// conv_13_acc_round_sat
// Accumulates KLEN signed products plus a per-window bias, then rounds,
// shifts and saturates the sum into one OUT_W result per window.
// Ports:
//   ap_clk, ap_rst_n                    clock, async active-low reset
//   cfg_bias                            bias, sampled with the first tap
//   s_prod_tdata/tvalid/tready          product input stream
//   m_tdata/m_tvalid/m_tready, m_sat    result stream, m_sat = clipped
// Macro CONV_13_RELU_EN (see conv_13_round_sat) rectifies the output.
// Window position lives in tap_cnt: taps 0..KLEN-2 accumulate, tap KLEN-1
// completes the sum and loads the output register.
module conv_13_acc_round_sat
  import conv_13_acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int KLEN   = DEF_KLEN,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic signed [PROD_W-1:0] s_prod_tdata,
  input  logic                     s_prod_tvalid,
  output logic                     s_prod_tready,
  output logic signed [OUT_W-1:0]  m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_sat
);

  localparam int CNT_W = $clog2(KLEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(KLEN - 1);

  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic signed [OUT_W-1:0] m_tdata_q, m_tdata_d;
  logic                    m_sat_q, m_sat_d;

  logic                    last_tap_s;
  logic                    accept_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] base_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [OUT_W-1:0] res_s;
  logic                    sat_s;

  assign last_tap_s = (tap_cnt_q == LAST_C);
  // Only the closing tap needs the output slot, so only it can be stalled.
  assign s_prod_tready = !(last_tap_s && m_tvalid_q && !m_tready);
  assign accept_s   = s_prod_tvalid && s_prod_tready;
  assign prod_ext_s = {{(ACC_W-PROD_W){s_prod_tdata[PROD_W-1]}}, s_prod_tdata};
  // The first tap of a window starts from the bias instead of the old sum.
  assign base_s     = (tap_cnt_q == {CNT_W{1'b0}}) ? cfg_bias : acc_q;
  assign sum_s      = base_s + prod_ext_s;

  conv_13_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .sum_i (sum_s),
    .res_o (res_s),
    .sat_o (sat_s)
  );

  // Next-state for the tap counter, accumulator and output register.
  always_comb begin
    tap_cnt_d  = tap_cnt_q;
    acc_d      = acc_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_sat_d    = m_sat_q;

    if (accept_s) begin
      acc_d = sum_s;
      if (last_tap_s) begin
        tap_cnt_d = {CNT_W{1'b0}};
      end else begin
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
      end
    end else begin
      acc_d     = acc_q;
      tap_cnt_d = tap_cnt_q;
    end

    // A new result may replace one retiring on the same edge (no bubble).
    if (accept_s && last_tap_s) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = res_s;
      m_sat_d    = sat_s;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end else begin
      m_tvalid_d = m_tvalid_q;
    end
  end

  // State registers; reset drops any partial window and the held result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tap_cnt_q  <= {CNT_W{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= {OUT_W{1'b0}};
      m_sat_q    <= 1'b0;
    end else begin
      tap_cnt_q  <= tap_cnt_d;
      acc_q      <= acc_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_sat_q    <= m_sat_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_sat    = m_sat_q;

endmodule : conv_13_acc_round_sat

// File: tb/tb_conv_13_acc_round_sat.sv
// tb_conv_13_acc_round_sat
// Directed vectors with hand-computed results for conv_13_acc_round_sat,
// followed by a random stream checked against an integer reference model.
// Honours CONV_13_RELU_EN for the expected negative results.
module tb_conv_13_acc_round_sat;

  logic               ap_clk;
  logic               ap_rst_n;
  logic signed [31:0] cfg_bias;
  logic signed [23:0] s_prod_tdata;
  logic               s_prod_tvalid;
  logic               s_prod_tready;
  logic signed [15:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_sat;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rnd_rdy = 1'b0;
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];

  conv_13_acc_round_sat dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .cfg_bias      (cfg_bias),
    .s_prod_tdata  (s_prod_tdata),
    .s_prod_tvalid (s_prod_tvalid),
    .s_prod_tready (s_prod_tready),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_sat         (m_sat)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Cycle counter for latency / throughput checks.
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Record every result that will retire on the coming rising edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && m_tvalid && m_tready) obs_q.push_back({m_sat, m_tdata});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: round half up, shift by 8, clip to 16 bits, optional ReLU.
  function automatic logic [16:0] model(input longint fin);
    longint r;
    logic [16:0] res;
    r = (fin + 128) >>> 8;
    if (r > 32767)       res = {1'b1, 16'h7fff};
    else if (r < -32768) res = {1'b1, 16'h8000};
    else                 res = {1'b0, r[15:0]};
`ifdef CONV_13_RELU_EN
    if (res[15]) res = 17'd0;
`endif
    return res;
  endfunction

  task automatic rnd_ready();
    if (rnd_rdy) m_tready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one product and hold it until accepted; ends at posedge + 1.
  task automatic send(input longint p);
    int n = 0;
    s_prod_tdata  = p[23:0];
    s_prod_tvalid = 1'b1;
    @(negedge ap_clk);
    while (!s_prod_tready && n < 200) begin
      @(posedge ap_clk); #1;
      rnd_ready();
      n++;
      @(negedge ap_clk);
    end
    if (!s_prod_tready) chk("send_timeout", 0, 1);
    @(posedge ap_clk); #1;
    s_prod_tvalid = 1'b0;
    rnd_ready();
  endtask

  task automatic idle();
    @(posedge ap_clk); #1;
    rnd_ready();
  endtask

  // One window: first product, eight copies of rest, then check the output.
  task automatic window(input string tag, input longint bias, input longint first,
                        input longint rest, input longint ed, input longint es);
    cfg_bias = bias[31:0];
    send(first);
    for (int k = 0; k < 7; k++) send(rest);
    chk({tag, "_pre_valid"}, m_tvalid, 0);
    send(rest);
    chk({tag, "_valid"}, m_tvalid, 1);
    chk({tag, "_data"}, $signed(m_tdata), ed);
    chk({tag, "_sat"}, m_sat, es);
  endtask

  initial begin
    longint neg1_exp, negsat_exp, negsat_flag;
    longint macc, pv, bias_v;
    int     mcnt, t0, n0, nchk;

`ifdef CONV_13_RELU_EN
    neg1_exp = 0; negsat_exp = 0; negsat_flag = 0;
`else
    neg1_exp = -1; negsat_exp = -32768; negsat_flag = 1;
`endif

    ap_rst_n = 1'b0; cfg_bias = 32'sd0; s_prod_tdata = 24'sd0;
    s_prod_tvalid = 1'b0; m_tready = 1'b1;
    #3;
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", $signed(m_tdata), 0);
    chk("rst_sat", m_sat, 0);
    chk("rst_ready", s_prod_tready, 1);
    #20 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Rounding and throughput: two back-to-back windows take 18 cycles.
    t0 = cyc;
    window("w256a", 0, 256, 256, 9, 0);
    window("w256b", 0, 256, 256, 9, 0);
    chk("throughput", cyc - t0, 18);

    // Rounding boundaries.
    window("r128", 0, 128, 0, 1, 0);
    window("r127", 0, 127, 0, 0, 0);
    window("rm129", 0, -129, 0, neg1_exp, 0);
    window("rm128", 0, -128, 0, 0, 0);

    // Bias and saturation.
    window("bias", 1000, 0, 0, 4, 0);
    window("satp", 0, 8388607, 8388607, 32767, 1);
    window("satn", 0, -8388608, -8388608, negsat_exp, negsat_flag);
    idle();

    // Backpressure: result held, middle taps flow, closing tap waits.
    m_tready = 1'b0;
    n0 = obs_q.size();
    window("bp1", 0, 256, 256, 9, 0);
    t0 = cyc;
    for (int k = 0; k < 8; k++) send(256);
    chk("bp_mid_cycles", cyc - t0, 8);
    chk("bp_hold_valid", m_tvalid, 1);
    chk("bp_hold_data", $signed(m_tdata), 9);
    s_prod_tdata = 24'sd256; s_prod_tvalid = 1'b1;
    @(negedge ap_clk);
    chk("bp_stall", s_prod_tready, 0);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk("bp_stall2", s_prod_tready, 0);
    chk("bp_hold2_data", $signed(m_tdata), 9);
    @(posedge ap_clk); #1;
    m_tready = 1'b1;
    @(negedge ap_clk);
    chk("bp_release", s_prod_tready, 1);
    @(posedge ap_clk); #1;
    s_prod_tvalid = 1'b0;
    chk("bp_new_valid", m_tvalid, 1);
    chk("bp_new_data", $signed(m_tdata), 9);
    chk("bp_retired1", obs_q.size(), n0 + 1);
    @(posedge ap_clk); #1;
    chk("bp_retired2", obs_q.size(), n0 + 2);
    chk("bp_empty", m_tvalid, 0);

    // Asynchronous reset in the middle of a window while a result is held.
    m_tready = 1'b0;
    window("pre_rst", 0, 256, 256, 9, 0);
    for (int k = 0; k < 5; k++) send(256);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst_valid", m_tvalid, 0);
    chk("arst_data", $signed(m_tdata), 0);
    #2 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    m_tready = 1'b1;
    window("post_rst", 0, 256, 256, 9, 0);
    idle();

    // Random stream against the reference model.
    obs_q.delete(); exp_q.delete();
    rnd_rdy = 1'b1; mcnt = 0; macc = 0;
    for (int i = 0; i < 9 * 1112; i++) begin
      if (mcnt == 0) begin
        bias_v = longint'($urandom_range(0, 2097152)) - 1048576;
        cfg_bias = bias_v[31:0];
        macc = bias_v;
      end
      pv = longint'($urandom_range(0, 24'hFFFFFF));
      if (pv >= 8388608) pv = pv - 16777216;
      pv = pv >>> $urandom_range(0, 12);
      if ($urandom_range(0, 15) == 0) pv = ($urandom_range(0, 1) != 0) ? 8388607 : -8388608;
      send(pv);
      macc += pv;
      mcnt++;
      if (mcnt == 9) begin
        exp_q.push_back(model(macc));
        mcnt = 0;
      end
      if ($urandom_range(0, 3) == 0) idle();
    end
    rnd_rdy = 1'b0;
    m_tready = 1'b1;
    repeat (5) idle();
    chk("rnd_count", obs_q.size(), exp_q.size());
    nchk = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) begin
      if (obs_q[i] !== exp_q[i]) chk("rnd_result", longint'(obs_q[i]), longint'(exp_q[i]));
    end
    chk("rnd_all_seen", nchk, 1112);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_conv_13_acc_round_sat

// File: doc/conv_13_acc_round_sat.md
Name: conv_13_acc_round_sat

Overview:
- Downstream consumer of the conv_13 16x8 signed multiplier, which produces 24-bit signed products.
- Accumulates KLEN consecutive products into one convolution output, adding a per-window bias.
- Applies round-half-up arithmetic right shift, saturates to 16 bits and emits one result per window over a valid/ready stream.
- Sits between the multiplier and the conv_13 output FIFO / next layer.

Parameters:
- PROD_W, 24, product width (signed).
- ACC_W, 32, accumulator width; must be >= PROD_W + clog2(KLEN) + 1.
- OUT_W, 16, output width (signed).
- KLEN, 9, products per output window; must be >= 2.
- SHIFT, 8, right-shift amount applied to the final sum; must be >= 1.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- cfg_bias  in  ACC_W  signed bias; sampled when the first tap of a window is accepted.
- s_prod_tdata  in  PROD_W  signed product from the multiplier.
- s_prod_tvalid  in  1  product valid.
- s_prod_tready  out  1  block accepts a product this cycle.
- m_tdata  out  OUT_W  signed rounded/saturated result.
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream accepts the result.
- m_sat  out  1  sideband, qualified by m_tvalid; 1 when the result was clipped.

Behaviour:
- Reset (async assert, sync release): tap_cnt=0, acc=0, m_tvalid=0, m_tdata=0, m_sat=0; any partial window is discarded.
- Input accept: a product is accepted when s_prod_tvalid && s_prod_tready.
  - tap_cnt==0: acc <= sext(cfg_bias) + sext(prod).
  - Otherwise: acc <= acc + sext(prod).
  - tap_cnt increments and wraps KLEN-1 -> 0.
- Last tap (tap_cnt==KLEN-1 and accepted):
  - final = acc + sext(prod).
  - r = (final + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed at ACC_W+1 bits.
  - If r > 2^(OUT_W-1)-1: output 2^(OUT_W-1)-1 with m_sat=1.
  - If r < -2^(OUT_W-1): output -2^(OUT_W-1) with m_sat=1.
  - Otherwise: output r with m_sat=0.
  - Result loads into the output register with m_tvalid=1 on the next edge.
  - Latency from last-tap accept to m_tvalid is 1 cycle.
- Output register:
  - m_tvalid, m_tdata and m_sat hold stable until m_tready is seen high.
  - m_tvalid clears on a handshake unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- Backpressure: s_prod_tready = !(tap_cnt==KLEN-1 && m_tvalid && !m_tready).
  - Non-final taps are never stalled, so the next window overlaps a held output.
  - Only the final tap waits for the output slot.
  - s_prod_tready is combinational from m_tready and registered state; there is no path from s_prod_tvalid.
- Simultaneous m_tready handshake and last-tap accept: allowed. The old result retires and the new result loads in the same edge; there is no bubble.
- The state machine is implicit in tap_cnt: ACC (tap_cnt 0..KLEN-2) -> LAST (tap_cnt==KLEN-1) -> ACC.
- Accumulator overflow cannot occur within the stated ACC_W constraint; no wrap checking.

Optional Feature:
- Macro CONV_13_RELU_EN.
- Defined: after saturation, negative results are replaced by 0. m_sat reflects only positive clipping; negative clipping to 0 sets m_sat=0.
- Undefined: signed output exactly as described above.

Decomposition:
- Package conv_13_acc_pkg holds:
  - Default widths PROD_W=24, ACC_W=32, OUT_W=16, KLEN=9, SHIFT=8.
  - Localparams OUT_MAX and OUT_MIN.
  - Typedefs prod_t, acc_t, out_t.
- Sub-module conv_13_round_sat: purely combinational. Takes ACC_W final sum, produces OUT_W result plus sat flag, with the RELU option inside. Instantiated once.

Test Plan:
- Rounding and throughput: bias=0; nine products of 256, m_tready=1 → one output m_tdata=9, m_sat=0, exactly 1 cycle after the 9th accept. Back-to-back windows give 1 output per 9 inputs with no stall.
- Rounding boundaries, bias=0: one product of 128 then eight 0 → 1; one of 127 then eight 0 → 0; one of -129 then eight 0 → -1; one of -128 then eight 0 → 0.
- Bias and saturation:
  - bias=1000, nine products of 0 → 4 (1128>>8).
  - Nine products of 8388607 → 32767 with m_sat=1.
  - Nine products of -8388608 → -32768 with m_sat=1; with CONV_13_RELU_EN → 0 with m_sat=0.
- Backpressure: m_tready=0, stream 18 products of 256.
  - First result is held stable.
  - Taps 10–17 are accepted; s_prod_tready drops at tap 18.
  - Raise m_tready → 9 retires and tap 18 is accepted in the same cycle; second result 9 appears next cycle.
- Reset mid-window: accept 5 taps, pulse ap_rst_n low asynchronously (between edges) → m_tvalid=0 immediately. Next 9 products of 256 with bias=0 yield exactly 9, proving the partial sum was discarded.
- Random: 10k products with random tvalid/m_tready against a reference model; no lost, duplicated or reordered results.
